video_timing_gen: RTL

//  Parametrised raster timing generator: counts pixels/lines at a pixel-enable rate and emits

---
 rtl/video_pkg.sv | 46 ++++
 rtl/video_axis_counter.sv | 51 +++++
 rtl/video_timing_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared definitions for the raster timing generator: axis totals, test pattern
// encodings and a few standard mode parameter sets.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BLACK = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_RAMP  = 2'd3
    } pattern_t;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_t;

    typedef struct packed {
        axis_t h;
        axis_t v;
    } mode_t;

    localparam mode_t MODE_256X224 = '{h: '{256, 24, 32, 72}, v: '{224, 16, 8, 16}};
    localparam mode_t MODE_320X240 = '{h: '{320, 24, 32, 48}, v: '{240, 4, 3, 15}};
    localparam mode_t MODE_640X480 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned h_total(input mode_t m);
        return axis_total(m.h.active, m.h.fp, m.h.sync, m.h.bp);
    endfunction

    function automatic int unsigned v_total(input mode_t m);
        return axis_total(m.v.active, m.v.fp, m.v.sync, m.v.bp);
    endfunction

    // First pixel index of colour bar k: smallest h with h*8/active >= k.
    function automatic int unsigned bar_threshold(input int unsigned k, input int unsigned active);
        return (k * active + 7) / 8;
    endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping position counter with registered blank/sync flags.
// Also exposes the next-state count/blank so the top can register aligned outputs.
module video_axis_counter #(
    parameter int unsigned TOTAL  = 384,
    parameter int unsigned ACTIVE = 256,
    parameter int unsigned FP     = 24,
    parameter int unsigned SYNC   = 32,
    parameter int unsigned CNT_W  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             blank,
    output logic             sync,
    output logic             wrap,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             blank_nxt
);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

    logic sync_nxt;

    assign wrap = (cnt == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (inc) begin
            cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        end
        blank_nxt = (cnt_nxt >= ACT_END);
        sync_nxt  = (cnt_nxt >= SYNC_START) && (cnt_nxt < SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= LAST;
            blank <= 1'b1;
            sync  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            blank <= blank_nxt;
            sync  <= sync_nxt;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Progressive raster timing generator (syncs, blanks, DE, strobes, position).
// Optional test pattern on r/g/b when VIDEO_TIMING_PATTERN_EN is defined.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 32,
    parameter int unsigned H_BP     = 72,
    parameter int unsigned V_ACTIVE = 224,
    parameter int unsigned V_FP     = 16,
    parameter int unsigned V_SYNC   = 8,
    parameter int unsigned V_BP     = 16,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [1:0]       pattern_sel,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hs,
    output logic             vs,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic             field,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > 2 ** CNT_W) begin : g_h_range
        $error("video_timing_gen: H_TOTAL exceeds 2**CNT_W");
    end
    if (V_TOTAL > 2 ** CNT_W) begin : g_v_range
        $error("video_timing_gen: V_TOTAL exceeds 2**CNT_W");
    end

    logic             h_sync, v_sync, h_wrap, v_wrap, h_blank_nxt, v_blank_nxt, de_nxt;
    logic [CNT_W-1:0] h_cnt_nxt, v_cnt_nxt;
    logic             unused_bits;

    video_axis_counter #(
        .TOTAL (H_TOTAL),
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .CNT_W (CNT_W)
    ) u_h (
        .clk      (pclk),
        .reset    (reset),
        .inc      (ce_pix),
        .cnt      (hcnt),
        .blank    (hblank),
        .sync     (h_sync),
        .wrap     (h_wrap),
        .cnt_nxt  (h_cnt_nxt),
        .blank_nxt(h_blank_nxt)
    );

    // Vertical steps on the same ce_pix cycle the horizontal wraps, so vs only moves at hcnt=0.
    video_axis_counter #(
        .TOTAL (V_TOTAL),
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .CNT_W (CNT_W)
    ) u_v (
        .clk      (pclk),
        .reset    (reset),
        .inc      (ce_pix & h_wrap),
        .cnt      (vcnt),
        .blank    (vblank),
        .sync     (v_sync),
        .wrap     (v_wrap),
        .cnt_nxt  (v_cnt_nxt),
        .blank_nxt(v_blank_nxt)
    );

    assign hs     = HS_POL ? h_sync : ~h_sync;
    assign vs     = VS_POL ? v_sync : ~v_sync;
    assign de_nxt = ~h_blank_nxt & ~v_blank_nxt;

    always_ff @(posedge pclk) begin
        if (reset) begin
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            field       <= 1'b0;
        end else begin
            de          <= de_nxt;
            line_start  <= ce_pix & h_wrap;
            frame_start <= ce_pix & h_wrap & v_wrap;
            if (ce_pix & h_wrap & v_wrap) begin
                field <= ~field;
            end
        end
    end

    assign unused_bits = ^{pattern_sel, h_cnt_nxt, v_cnt_nxt};

`ifdef VIDEO_TIMING_PATTERN_EN
    logic [23:0] rgb;
    logic [2:0]  bar_nxt;

    // Bar index via constant thresholds instead of a runtime divide by H_ACTIVE.
    always_comb begin
        bar_nxt = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (h_cnt_nxt >= CNT_W'(bar_threshold(k, H_ACTIVE))) begin
                bar_nxt = 3'(k);
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            rgb <= '0;
        end else if (ce_pix) begin
            if (!de_nxt) begin
                rgb <= '0;
            end else begin
                case (pattern_t'(pattern_sel))
                    PAT_BLACK: rgb <= '0;
                    PAT_CHECK: rgb <= (h_cnt_nxt[3] ^ v_cnt_nxt[3]) ? '1 : '0;
                    PAT_BARS:  rgb <= {{8{bar_nxt[2]}}, {8{bar_nxt[1]}}, {8{bar_nxt[0]}}};
                    PAT_RAMP:  rgb <= {3{8'(h_cnt_nxt)}};
                    default:   rgb <= '0;
                endcase
            end
        end
    end

    assign {r, g, b} = rgb;
`else
    assign r = '0;
    assign g = '0;
    assign b = '0;
`endif

endmodule
